logic_unit_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one registered 8-bit bitwise logic unit (NOR/AND/OR/XOR) among N_REQ processor cores of the multiprocessed architecture.
- Each core raises a request with its operands and operation.
- The arbiter grants one core at a time, latches that core's inputs, executes, and returns the result tagged with the requester index.

---
 rtl/logic_unit_arbiter_if.sv | 55 +++++
 rtl/logic_unit_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_arbiter_if.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter_if
// Bundles the request/operand bus and the grant/result bus between the
// processor cores and the shared logic-unit arbiter.
//
// Parameters : N_REQ (number of cores), WIDTH (operand width), ID_W (index width)
// Signals    : req, op, a_in, b_in          core -> arbiter
//              grant, done, result,
//              result_valid, result_id, busy arbiter -> cores
//              op_count, last_wait           arbiter -> cores, only when
//                                            LOGIC_ARB_STATS_EN is defined
// Modports   : master (core side), slave (arbiter side)
// -----------------------------------------------------------------------------
interface logic_unit_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) ();
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [WIDTH*N_REQ-1:0] a_in;
    logic [WIDTH*N_REQ-1:0] b_in;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       result;
    logic                   result_valid;
    logic [ID_W-1:0]        result_id;
    logic                   busy;
`ifdef LOGIC_ARB_STATS_EN
    logic [15:0]            op_count;
    logic [7:0]             last_wait;

    modport master (
        output req, op, a_in, b_in,
        input  grant, done, result, result_valid, result_id, busy,
        input  op_count, last_wait
    );

    modport slave (
        input  req, op, a_in, b_in,
        output grant, done, result, result_valid, result_id, busy,
        output op_count, last_wait
    );
`else
    modport master (
        output req, op, a_in, b_in,
        input  grant, done, result, result_valid, result_id, busy
    );

    modport slave (
        input  req, op, a_in, b_in,
        output grant, done, result, result_valid, result_id, busy
    );
`endif
endinterface

// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
// Round-robin arbiter and sequencer sharing one registered bitwise logic unit
// (NOR/AND/OR/XOR) among N_REQ cores. Each operation takes three cycles:
// IDLE (arbitrate and latch), EXEC (compute), DONE (deliver).
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - logic_unit_arbiter_if.slave: req/op/a_in/b_in in,
//          grant/done/result/result_valid/result_id/busy out
//
// Optional feature macro: LOGIC_ARB_STATS_EN
//   Adds op_count (saturating count of completed operations) and last_wait
//   (cycles the winner's req was high up to and including its accept cycle).
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    logic_unit_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // After reset core 0 must have first priority, so the "previous" owner is N_REQ-1.
    localparam logic [ID_W-1:0]  LAST_ID_RST = ID_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_LSB     = N_REQ'(1);

    state_t           state_q, state_d;
    logic [ID_W-1:0]  last_id_q, last_id_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic [ID_W-1:0]  result_id_q, result_id_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             result_valid_q, result_valid_d;
    logic             busy_q, busy_d;

    logic             win_found_s;
    logic [ID_W-1:0]  win_id_s;
    logic [1:0]       win_op_s;
    logic [WIDTH-1:0] win_a_s;
    logic [WIDTH-1:0] win_b_s;
    logic             accept_s;
    int               dist_s;
    int               best_dist_s;

    function automatic logic [WIDTH-1:0] logic_fn(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = ~(a | b);
            2'b01:   r = a & b;
            2'b10:   r = a | b;
            2'b11:   r = a ^ b;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Round-robin winner: smallest upward distance from last_id+1 among active requests.
    always_comb begin
        win_id_s    = {ID_W{1'b0}};
        win_op_s    = 2'b00;
        win_a_s     = {WIDTH{1'b0}};
        win_b_s     = {WIDTH{1'b0}};
        best_dist_s = N_REQ;
        dist_s      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // Distance 0 belongs to the core right after the previous owner.
            dist_s = (i + N_REQ - 1 - int'(last_id_q)) % N_REQ;
            if (bus.req[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                win_id_s    = ID_W'(i);
                win_op_s    = bus.op[2*i +: 2];
                win_a_s     = bus.a_in[WIDTH*i +: WIDTH];
                win_b_s     = bus.b_in[WIDTH*i +: WIDTH];
            end else begin
                best_dist_s = best_dist_s;
            end
        end
        win_found_s = |bus.req;
    end

    assign accept_s = (state_q == ST_IDLE) && win_found_s;

    // Sequencer next state: accept in IDLE, compute in EXEC, deliver in DONE.
    always_comb begin
        state_d        = state_q;
        last_id_d      = last_id_q;
        cur_id_d       = cur_id_q;
        result_id_d    = result_id_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        result_d       = result_q;
        grant_d        = grant_q;
        busy_d         = busy_q;
        done_d         = {N_REQ{1'b0}};
        result_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d     = win_op_s;
                    a_d      = win_a_s;
                    b_d      = win_b_s;
                    cur_id_d = win_id_s;
                    grant_d  = ONE_LSB << win_id_s;
                    busy_d   = 1'b1;
                    state_d  = ST_EXEC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // done/result_valid are registered here so they are high during DONE.
                result_d       = logic_fn(op_q, a_q, b_q);
                result_id_d    = cur_id_q;
                done_d         = ONE_LSB << cur_id_q;
                result_valid_d = 1'b1;
                state_d        = ST_DONE;
            end
            ST_DONE: begin
                last_id_d = cur_id_q;
                grant_d   = {N_REQ{1'b0}};
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                grant_d = {N_REQ{1'b0}};
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            last_id_q      <= LAST_ID_RST;
            cur_id_q       <= {ID_W{1'b0}};
            result_id_q    <= {ID_W{1'b0}};
            op_q           <= 2'b00;
            a_q            <= {WIDTH{1'b0}};
            b_q            <= {WIDTH{1'b0}};
            result_q       <= {WIDTH{1'b0}};
            grant_q        <= {N_REQ{1'b0}};
            done_q         <= {N_REQ{1'b0}};
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_id_q      <= last_id_d;
            cur_id_q       <= cur_id_d;
            result_id_q    <= result_id_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            result_q       <= result_d;
            grant_q        <= grant_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_id    = result_id_q;
    assign bus.busy         = busy_q;

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [7:0]  last_wait_q, last_wait_d;
    logic [7:0]  wait_q [N_REQ];
    logic [7:0]  wait_d [N_REQ];
    logic [7:0]  win_wait_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Per-core wait counters; a counter restarts once its core is accepted or owns the unit.
    always_comb begin
        win_wait_s = 8'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id_s == ID_W'(i)) begin
                win_wait_s = wait_q[i];
            end else begin
                win_wait_s = win_wait_s;
            end
            if (grant_q[i] || (accept_s && (win_id_s == ID_W'(i)))) begin
                wait_d[i] = 8'd0;
            end else if (bus.req[i]) begin
                wait_d[i] = sat_inc8(wait_q[i]);
            end else begin
                wait_d[i] = 8'd0;
            end
        end
        // The accept cycle itself counts as a waiting cycle.
        if (accept_s) begin
            last_wait_d = sat_inc8(win_wait_s);
        end else begin
            last_wait_d = last_wait_q;
        end
        if (state_q == ST_DONE) begin
            op_count_d = sat_inc16(op_count_q);
        end else begin
            op_count_d = op_count_q;
        end
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q  <= 16'd0;
            last_wait_q <= 8'd0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_q[i] <= 8'd0;
            end
        end else begin
            op_count_q  <= op_count_d;
            last_wait_q <= last_wait_d;
            for (int i = 0; i < N_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign bus.op_count  = op_count_q;
    assign bus.last_wait = last_wait_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_arbiter
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-timed reference model (accept cycle,
// +1/+2 ownership window, rotating priority from the last delivered owner).
// -----------------------------------------------------------------------------
module tb_logic_unit_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

    logic_unit_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks;
    int n_fail;

    // Reference model state
    int         cyc;
    int         acc;          // cycle in which the current/last op was accepted
    int         cur;          // owner of that op
    int         last;         // owner of the last delivered op
    logic [7:0] cur_res;
    logic [7:0] exp_result;
    int         exp_rid;
    int         hi_cnt [N_REQ];
    int         exp_last_wait;
    int         exp_ops;
    int         done_log [$];
    int         done_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            case (op)
                2'b00:   r[k] = (a[k] == 1'b0 && b[k] == 1'b0);
                2'b01:   r[k] = (a[k] == 1'b1 && b[k] == 1'b1);
                2'b10:   r[k] = (a[k] == 1'b1 || b[k] == 1'b1);
                default: r[k] = (a[k] != b[k]);
            endcase
        end
        return r;
    endfunction

    // Evaluate the current cycle's inputs (reset, wait counting, arbitration).
    task automatic model_eval();
        int w;
        if (rst) begin
            acc = -10; last = N_REQ - 1; exp_result = 8'h00; exp_rid = 0;
            exp_last_wait = 0; exp_ops = 0;
            for (int i = 0; i < N_REQ; i++) hi_cnt[i] = 0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if ((cyc == acc + 1 || cyc == acc + 2) && cur == i) hi_cnt[i] = 0;
                else if (bus.req[i]) hi_cnt[i] = (hi_cnt[i] >= 255) ? 255 : hi_cnt[i] + 1;
                else hi_cnt[i] = 0;
            end
            if (cyc >= acc + 3 && bus.req != '0) begin
                w = -1;
                for (int k = 1; k <= N_REQ; k++) begin
                    if (w < 0 && bus.req[(last + k) % N_REQ]) w = (last + k) % N_REQ;
                end
                acc = cyc;
                cur = w;
                cur_res = ref_fn(bus.op[2*w +: 2], bus.a_in[8*w +: 8], bus.b_in[8*w +: 8]);
                exp_last_wait = hi_cnt[w];
                hi_cnt[w] = 0;
            end
        end
    endtask

    // Compare all outputs for the current cycle against the model.
    task automatic check_outputs();
        logic [N_REQ-1:0] eg;
        logic [N_REQ-1:0] ed;
        eg = (cyc == acc + 1 || cyc == acc + 2) ? (N_REQ'(1) << cur) : '0;
        ed = (cyc == acc + 2) ? (N_REQ'(1) << cur) : '0;
        if (cyc == acc + 2) begin
            exp_result = cur_res;
            exp_rid    = cur;
            last       = cur;
        end
        chk("grant", bus.grant, eg);
        chk("done", bus.done, ed);
        chk("result_valid", bus.result_valid, (cyc == acc + 2) ? 1 : 0);
        chk("busy", bus.busy, (eg != '0) ? 1 : 0);
        chk("result", bus.result, exp_result);
        chk("result_id", bus.result_id, exp_rid);
`ifdef LOGIC_ARB_STATS_EN
        chk("last_wait", bus.last_wait, exp_last_wait);
        chk("op_count", bus.op_count, exp_ops);
        if (cyc == acc + 2) exp_ops = (exp_ops >= 65535) ? 65535 : exp_ops + 1;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.done[i] === 1'b1) begin
                done_log.push_back(i);
                done_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic set_core(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.op[2*i +: 2]   = op;
        bus.a_in[8*i +: 8] = a;
        bus.b_in[8*i +: 8] = b;
    endtask

    logic [1:0] t2_op  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [7:0] t2_exp [4] = '{8'h0A, 8'hAF, 8'hA5, 8'h50};

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; acc = -10; cur = 0; last = N_REQ - 1;
        cur_res = 8'h00; exp_result = 8'h00; exp_rid = 0; exp_last_wait = 0; exp_ops = 0;
        for (int i = 0; i < N_REQ; i++) hi_cnt[i] = 0;
        rst = 1'b1; bus.req = '0; bus.op = '0; bus.a_in = '0; bus.b_in = '0;
        tick(); tick();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_result", bus.result, 8'h00);
        rst = 1'b0;

        // Single NOR request from core 0
        set_core(0, 2'b00, 8'hF0, 8'h0C); bus.req = 4'b0001; tick();
        chk("t1_grant", bus.grant, 4'b0001);
        bus.req = '0; tick();
        chk("t1_done", bus.done, 4'b0001);
        chk("t1_valid", bus.result_valid, 1'b1);
        chk("t1_result", bus.result, 8'h03);
        chk("t1_id", bus.result_id, 0);
        tick();

        // Op coverage on core 2
        for (int t = 0; t < 4; t++) begin
            set_core(2, t2_op[t], 8'hAA, 8'h0F); bus.req = 4'b0100; tick();
            bus.req = '0; tick();
            chk("t2_result", bus.result, t2_exp[t]);
            chk("t2_id", bus.result_id, 2);
            tick();
        end

        // All requesters active: rotation 0,1,2,3,0 with 3-cycle spacing
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_core(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        done_log.delete(); done_cyc.delete();
        bus.req = 4'b1111;
        repeat (15) tick();
        bus.req = '0;
        repeat (3) tick();
        chk("t3_count", done_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("t3_order", (i < done_log.size()) ? done_log[i] : -1, i % N_REQ);
            if (i > 0) chk("t3_spacing", (i < done_cyc.size()) ? done_cyc[i] - done_cyc[i-1] : -1, 3);
        end

        // Operand change during EXEC must not corrupt the latched value
        set_core(1, 2'b00, 8'h00, 8'h00); bus.req = 4'b0010; tick();
        chk("t4_grant", bus.grant, 4'b0010);
        bus.a_in[15:8] = 8'hFF; bus.req = '0; tick();
        chk("t4_result", bus.result, 8'hFF);
        tick();

        // Reset during EXEC of core 3
        set_core(3, 2'b10, 8'h12, 8'h34); bus.req = 4'b1000; tick();
        chk("t5_grant", bus.grant, 4'b1000);
        rst = 1'b1; bus.req = '0; tick();
        chk("t5_grant0", bus.grant, 4'b0000);
        chk("t5_done0", bus.done, 4'b0000);
        chk("t5_result0", bus.result, 8'h00);
        chk("t5_busy0", bus.busy, 1'b0);
        rst = 1'b0; tick();
        chk("t5_nodone", bus.done, 4'b0000);
        set_core(0, 2'b01, 8'h3C, 8'hFF); set_core(2, 2'b11, 8'h0F, 8'hFF);
        bus.req = 4'b0101; tick();
        chk("t5_first", bus.grant, 4'b0001);
        bus.req = 4'b0100; tick(); tick(); tick(); tick();
        chk("t5_second", bus.grant, 4'b0100);
        bus.req = '0; repeat (3) tick();

`ifdef LOGIC_ARB_STATS_EN
        // Stats: waiting core and completed-operation count
        rst = 1'b1; tick(); rst = 1'b0;
        set_core(0, 2'b01, 8'h11, 8'h22); set_core(1, 2'b10, 8'h33, 8'h44);
        bus.req = 4'b0011; tick();
        bus.req = 4'b0010; tick(); tick(); tick();
        chk("st_last_wait", bus.last_wait, 8'd4);
        bus.req = '0; tick(); tick();
        for (int t = 0; t < 3; t++) begin
            bus.req = 4'b0100; tick();
            bus.req = '0; tick(); tick();
        end
        chk("st_op_count", bus.op_count, 16'd5);
`endif

        // Randomized traffic with occasional resets and changing operands
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            bus.req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            for (int i = 0; i < N_REQ; i++) set_core(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            tick();
        end
        rst = 1'b0; bus.req = '0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
